dac_mixer_ctrl: RTL and testbench

DAC_MIXER_CTRL -- requirements
Module: dac_mixer_ctrl

---
 rtl/dac_mixer_ctrl_pkg.sv | 25 ++
 rtl/dac_mixer_ctrl_gain_ramp.sv | 65 ++++++
 rtl/dac_mixer_ctrl.sv | 118 +++++++++++
 tb/tb_dac_mixer_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_mixer_ctrl_pkg.sv
// Shared definitions for the DAC mixer controller.
// Holds channel and DAC code widths, the gain width helper and the
// power-state encoding used by the top-level FSM.
package dac_mixer_ctrl_pkg;

  localparam int unsigned CH_W         = 4;
  // DAC input width (MSBI + 1); 2 * 15 = 30 fits without overflow.
  localparam int unsigned DAC_W        = 5;
  localparam int unsigned GAIN_MAX_DEF = 16;

  // Gain runs 0..gain_max inclusive, so it needs one bit above log2.
  function automatic int unsigned gain_width(input int unsigned gain_max);
    return $clog2(gain_max) + 1;
  endfunction

  localparam int unsigned GAIN_W = gain_width(GAIN_MAX_DEF);

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StRampUp = 2'd1,
    StOn     = 2'd2,
    StRampDn = 2'd3
  } state_e;

endpackage

// File: rtl/dac_mixer_ctrl_gain_ramp.sv
// Ramp divider plus up/down saturating gain counter.
// Ports:
//   Clk, Reset_n  - system clock, asynchronous active-low reset
//   up_i, dn_i    - ramp direction requests (mutually exclusive)
//   clr_i         - clear the divider (state transition in the parent)
//   gain_next_o   - next-state gain, i.e. the value the register takes at
//                   the coming edge; lets the parent update outputs and
//                   state in the same clock as the step.
module dac_mixer_ctrl_gain_ramp
  import dac_mixer_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 256,
  parameter int unsigned GAIN_MAX = 16,
  localparam int unsigned GW      = gain_width(GAIN_MAX)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          up_i,
  input  logic          dn_i,
  input  logic          clr_i,
  output logic [GW-1:0] gain_next_o
);

  localparam int unsigned    DivW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(RAMP_DIV - 1);
  localparam logic [GW-1:0]   GainMax = GW'(GAIN_MAX);

  logic [DivW-1:0] div_q, div_d;
  logic [GW-1:0]   gain_q, gain_d;
  logic            step;

  // Step and gain kept apart from the divider update so the parent's
  // transition-driven clear never feeds back into the gain path.
  always_comb begin
    step   = (up_i || dn_i) && (div_q == DivLast);
    gain_d = gain_q;
    if (step && up_i && (gain_q < GainMax)) begin
      gain_d = gain_q + 1'b1;
    end else if (step && dn_i && (gain_q != '0)) begin
      gain_d = gain_q - 1'b1;
    end
  end

  // Divider idles at zero when not ramping, so every ramp entry starts a
  // full RAMP_DIV interval.
  always_comb begin
    div_d = div_q + 1'b1;
    if (clr_i || !(up_i || dn_i) || (div_q == DivLast)) begin
      div_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q  <= '0;
      gain_q <= '0;
    end else begin
      div_q  <= div_d;
      gain_q <= gain_d;
    end
  end

  assign gain_next_o = gain_d;

endmodule

// File: rtl/dac_mixer_ctrl.sv
// Two-channel volume mixer with a soft on/off gain ramp feeding a
// delta-sigma DAC.
// Ports:
//   Clk, Reset_n       - system clock, asynchronous active-low reset
//   SampleStb          - sample tick; channel volumes/enables captured on it
//   Ch0In, Ch1In       - channel volumes 0..15
//   Ch0En, Ch1En       - channel enables
//   Enable             - audio on/off request (level)
//   DacIn              - registered DAC code, (mix * gain) >> log2(GAIN_MAX)
//   DacRst             - DAC reset, high while silent (OFF)
//   Active             - high in any state but OFF
//   Settled            - high in ON or OFF
module dac_mixer_ctrl
  import dac_mixer_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 256,
  parameter int unsigned GAIN_MAX = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             SampleStb,
  input  logic [CH_W-1:0]  Ch0In,
  input  logic [CH_W-1:0]  Ch1In,
  input  logic             Ch0En,
  input  logic             Ch1En,
  input  logic             Enable,
  output logic [DAC_W-1:0] DacIn,
  output logic             DacRst,
  output logic             Active,
  output logic             Settled
);

  localparam int unsigned   GW      = gain_width(GAIN_MAX);
  localparam int unsigned   Shift   = $clog2(GAIN_MAX);
  localparam int unsigned   ProdW   = DAC_W + GW;
  localparam logic [GW-1:0] GainMax = GW'(GAIN_MAX);

  state_e              state_q, state_d;
  logic [DAC_W-1:0]    mix_q, mix_d;
  logic [DAC_W-1:0]    dac_q, dac_d;
  logic [GW-1:0]       gain_next;
  logic [ProdW-1:0]    prod;
  logic                ramp_up, ramp_dn, div_clr;

  // A direction reversal suppresses the step so gain is kept as-is.
  assign ramp_up = (state_q == StRampUp) && Enable;
  assign ramp_dn = (state_q == StRampDn) && !Enable;
  assign div_clr = (state_d != state_q);

  dac_mixer_ctrl_gain_ramp #(
    .RAMP_DIV (RAMP_DIV),
    .GAIN_MAX (GAIN_MAX)
  ) u_gain_ramp (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .up_i        (ramp_up),
    .dn_i        (ramp_dn),
    .clr_i       (div_clr),
    .gain_next_o (gain_next)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff: begin
        if (Enable) state_d = StRampUp;
      end
      StRampUp: begin
        if (!Enable) begin
          state_d = StRampDn;
        end else if (gain_next == GainMax) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (!Enable) state_d = StRampDn;
      end
      StRampDn: begin
        if (Enable) begin
          state_d = StRampUp;
        end else if (gain_next == '0) begin
          state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_comb begin
    mix_d = mix_q;
    if (SampleStb) begin
      mix_d = (Ch0En ? {1'b0, Ch0In} : '0) + (Ch1En ? {1'b0, Ch1In} : '0);
    end
  end

  // Built from next-state mix and gain so a coincident strobe and gain
  // step land in one update; the code otherwise holds naturally.
  assign prod  = ProdW'(mix_d) * ProdW'(gain_next);
  assign dac_d = DAC_W'(prod >> Shift);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StOff;
      mix_q   <= '0;
      dac_q   <= '0;
    end else begin
      state_q <= state_d;
      mix_q   <= mix_d;
      dac_q   <= dac_d;
    end
  end

  assign DacIn   = dac_q;
  assign DacRst  = (state_q == StOff);
  assign Active  = (state_q != StOff);
  assign Settled = (state_q == StOn) || (state_q == StOff);

endmodule

// File: tb/tb_dac_mixer_ctrl.sv
// Scoreboard bench for dac_mixer_ctrl at RAMP_DIV = 4, GAIN_MAX = 16.
// Stimulus pushes expected outputs; the monitor pops and compares on the
// falling edge.
module tb_dac_mixer_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       SampleStb;
  logic [3:0] Ch0In, Ch1In;
  logic       Ch0En, Ch1En, Enable;
  logic [4:0] DacIn;
  logic       DacRst, Active, Settled;

  always #5 Clk = ~Clk;

  dac_mixer_ctrl #(
    .RAMP_DIV (4),
    .GAIN_MAX (16)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .SampleStb (SampleStb),
    .Ch0In     (Ch0In),
    .Ch1In     (Ch1In),
    .Ch0En     (Ch0En),
    .Ch1En     (Ch1En),
    .Enable    (Enable),
    .DacIn     (DacIn),
    .DacRst    (DacRst),
    .Active    (Active),
    .Settled   (Settled)
  );

  typedef struct {
    string      name;
    logic [4:0] dac;
    logic       rst;
    logic       act;
    logic       set;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // floor(30 * g / 16) for g = 0..16, worked by hand.
  logic [4:0] tab30 [0:16] = '{5'd0, 5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15,
                               5'd16, 5'd18, 5'd20, 5'd22, 5'd24, 5'd26, 5'd28, 5'd30};

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (DacIn !== e.dac || DacRst !== e.rst || Active !== e.act || Settled !== e.set) begin
          bad++;
          $display("FAIL %s: got DacIn=%0d DacRst=%b Active=%b Settled=%b, want DacIn=%0d DacRst=%b Active=%b Settled=%b",
                   e.name, DacIn, DacRst, Active, Settled, e.dac, e.rst, e.act, e.set);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [4:0] d, input logic r, input logic a,
                     input logic s);
    exp_t e;
    e.name = n;
    e.dac  = d;
    e.rst  = r;
    e.act  = a;
    e.set  = s;
    sb.push_back(e);
    @(negedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    SampleStb = 1'b0;
    Ch0In     = 4'd0;
    Ch1In     = 4'd0;
    Ch0En     = 1'b0;
    Ch1En     = 1'b0;
    Enable    = 1'b0;
    repeat (2) tick();
    chk("reset", 5'd0, 1'b1, 1'b0, 1'b1);
    Reset_n = 1'b1;
    tick();

    // Strobing while off leaves the output silent.
    Ch0In = 4'd15; Ch0En = 1'b1; SampleStb = 1'b1;
    tick();
    SampleStb = 1'b0;
    chk("off_strobe", 5'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    chk("off_hold", 5'd0, 1'b1, 1'b0, 1'b1);

    // Full-scale ramp with mix = 30.
    Ch1In = 4'd15; Ch1En = 1'b1; SampleStb = 1'b1;
    tick();
    SampleStb = 1'b0;
    chk("mix30_off", 5'd0, 1'b1, 1'b0, 1'b1);
    Enable = 1'b1;
    tick();
    chk("up_entry", 5'd0, 1'b0, 1'b1, 1'b0);
    for (int g = 1; g <= 16; g++) begin
      repeat (3) tick();
      if (g == 1) chk("up_hold3", 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      chk($sformatf("up_g%0d", g), tab30[g], 1'b0, 1'b1, (g == 16));
    end

    // ON: strobe updates the code one clock later; no strobe, no change.
    Ch0In = 4'd9; Ch1En = 1'b0; SampleStb = 1'b1;
    tick();
    SampleStb = 1'b0;
    chk("on_strobe9", 5'd9, 1'b0, 1'b1, 1'b1);
    Ch0In = 4'd3;
    repeat (2) tick();
    chk("on_nostrobe", 5'd9, 1'b0, 1'b1, 1'b1);

    // Ramp down from ON; strobe mix = 16 on the first step edge.
    Enable = 1'b0;
    tick();
    chk("dn_entry", 5'd9, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    Ch0In = 4'd8; Ch1In = 4'd8; Ch0En = 1'b1; Ch1En = 1'b1; SampleStb = 1'b1;
    tick();
    SampleStb = 1'b0;
    chk("coincide_g15", 5'd15, 1'b0, 1'b1, 1'b0);
    repeat (56) tick();
    chk("dn_g1", 5'd1, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("dn_g1_hold", 5'd1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("off_from_on", 5'd0, 1'b1, 1'b0, 1'b1);

    // Up to gain 8 with mix 16, then drop Enable.
    Enable = 1'b1;
    tick();
    chk("up2_entry", 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (32) tick();
    chk("up_g8", 5'd8, 1'b0, 1'b1, 1'b0);
    Enable = 1'b0;
    tick();
    chk("dn8_entry", 5'd8, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    chk("dn_g7", 5'd7, 1'b0, 1'b1, 1'b0);
    repeat (27) tick();
    chk("dn8_g1", 5'd1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("off_after32", 5'd0, 1'b1, 1'b0, 1'b1);

    // Reverse direction at gain 5 during a ramp down.
    Enable = 1'b1;
    tick();
    repeat (24) tick();
    chk("up_g6", 5'd6, 1'b0, 1'b1, 1'b0);
    Enable = 1'b0;
    tick();
    chk("dn6_entry", 5'd6, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    chk("dn_g5", 5'd5, 1'b0, 1'b1, 1'b0);
    Enable = 1'b1;
    tick();
    chk("rev_entry", 5'd5, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("rev_hold", 5'd5, 1'b0, 1'b1, 1'b0);
    tick();
    chk("rev_g6", 5'd6, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-ramp at gain 10, then restart from zero.
    repeat (16) tick();
    chk("up_g10", 5'd10, 1'b0, 1'b1, 1'b0);
    tick();
    Reset_n = 1'b0;
    #1;
    chk("async_rst", 5'd0, 1'b1, 1'b0, 1'b1);
    Reset_n = 1'b1;
    tick();
    chk("restart_entry", 5'd0, 1'b0, 1'b1, 1'b0);
    SampleStb = 1'b1;
    tick();
    SampleStb = 1'b0;
    repeat (3) tick();
    chk("restart_g1", 5'd1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge Clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
